// File: rtl/wb_pkg.sv
// Shared types for the write-back arbiter: register/data widths, queue entry
// layout and the write-source tag.
package wb_pkg;

    localparam int REG_AW = 5;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_PIPE,
        SRC_MDU
    } wb_src_t;

endpackage

// File: rtl/wb_queue.sv
// Circular MDU result queue with kill-by-address and two busy lookup ports.
// Optional macro WB_TRACE_EN prints a line for each killed entry.
module wb_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enq,
    input  logic [REG_AW-1:0]      enq_addr,
    input  logic [DATA_W-1:0]      enq_data,
    input  logic                   pop,
    input  logic                   kill_en,
    input  logic [REG_AW-1:0]      kill_addr,
    input  logic [REG_AW-1:0]      lk_addr1,
    input  logic [REG_AW-1:0]      lk_addr2,
    output logic                   lk_hit1,
    output logic                   lk_hit2,
    output logic                   head_valid,
    output logic [REG_AW-1:0]      head_addr,
    output logic [DATA_W-1:0]      head_data,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        mem_q [DEPTH];
    wb_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Kill is applied before the enqueue write so a same-cycle MDU result
    // (younger than the pipe write) survives. Popped slots are invalidated
    // so stale entries never show up in the busy lookup.
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (kill_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (mem_q[i].addr == kill_addr) begin
                    mem_d[i].valid = 1'b0;
                end
            end
        end
        if (pop) begin
            mem_d[head_q].valid = 1'b0;
            head_d              = head_q + PTR_W'(1);
        end
        if (enq) begin
            mem_d[tail_q] = '{valid: 1'b1, addr: enq_addr, data: enq_data};
            tail_d        = tail_q + PTR_W'(1);
        end
        case ({enq, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

    always_comb begin
        lk_hit1 = 1'b0;
        lk_hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem_q[i].valid && (mem_q[i].addr == lk_addr1)) lk_hit1 = 1'b1;
            if (mem_q[i].valid && (mem_q[i].addr == lk_addr2)) lk_hit2 = 1'b1;
        end
    end

    assign head_valid = mem_q[head_q].valid;
    assign head_addr  = mem_q[head_q].addr;
    assign head_data  = mem_q[head_q].data;
    assign empty      = (count_q == '0);
    assign full       = (count_q == CNT_W'(DEPTH));
    assign count      = count_q;

`ifdef WB_TRACE_EN
    always @(posedge clk) begin
        if (rst_n && kill_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (mem_q[i].valid && (mem_q[i].addr == kill_addr)) begin
                    $display("wb_trace KILL slot=%0d addr=%0d data=%08h", i, mem_q[i].addr, mem_q[i].data);
                end
            end
        end
    end
`endif

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline write-back has priority, MDU
// results drain from wb_queue. Optional macro WB_TRACE_EN traces every write.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pipe_wr_en,
    input  logic [REG_AW-1:0]      pipe_wr_addr,
    input  logic [DATA_W-1:0]      pipe_wr_data,
    input  logic                   mdu_valid,
    output logic                   mdu_ready,
    input  logic [REG_AW-1:0]      mdu_addr,
    input  logic [DATA_W-1:0]      mdu_data,
    input  logic [REG_AW-1:0]      chk_addr1,
    input  logic [REG_AW-1:0]      chk_addr2,
    output logic                   chk_busy1,
    output logic                   chk_busy2,
    output logic                   rf_wr_en,
    output logic [REG_AW-1:0]      rf_wr_addr,
    output logic [DATA_W-1:0]      rf_wr_data,
    output logic [$clog2(DEPTH):0] q_count
);

    logic              pipe_eff;
    logic              enq;
    logic              pop;
    logic              q_full;
    logic              q_empty;
    logic              head_valid;
    logic [REG_AW-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic              hit1, hit2;

    logic              rf_wr_en_q, rf_wr_en_d;
    logic [REG_AW-1:0] rf_wr_addr_q, rf_wr_addr_d;
    logic [DATA_W-1:0] rf_wr_data_q, rf_wr_data_d;
    wb_src_t           src_q, src_d;

    // Writes to R0 are architecturally meaningless, so they never reach the queue.
    assign pipe_eff  = pipe_wr_en && (pipe_wr_addr != '0);
    assign mdu_ready = !q_full;
    assign enq       = mdu_valid && mdu_ready && (mdu_addr != '0);

    wb_queue #(.DEPTH(DEPTH)) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .enq        (enq),
        .enq_addr   (mdu_addr),
        .enq_data   (mdu_data),
        .pop        (pop),
        .kill_en    (pipe_eff),
        .kill_addr  (pipe_wr_addr),
        .lk_addr1   (chk_addr1),
        .lk_addr2   (chk_addr2),
        .lk_hit1    (hit1),
        .lk_hit2    (hit2),
        .head_valid (head_valid),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .empty      (q_empty),
        .full       (q_full),
        .count      (q_count)
    );

    always_comb begin
        rf_wr_en_d   = 1'b0;
        rf_wr_addr_d = rf_wr_addr_q;
        rf_wr_data_d = rf_wr_data_q;
        src_d        = SRC_NONE;
        pop          = 1'b0;
        if (pipe_eff) begin
            rf_wr_en_d   = 1'b1;
            rf_wr_addr_d = pipe_wr_addr;
            rf_wr_data_d = pipe_wr_data;
            src_d        = SRC_PIPE;
        end else if (!q_empty) begin
            // A killed head is popped without issuing a write.
            pop = 1'b1;
            if (head_valid) begin
                rf_wr_en_d   = 1'b1;
                rf_wr_addr_d = head_addr;
                rf_wr_data_d = head_data;
                src_d        = SRC_MDU;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wr_en_q   <= 1'b0;
            rf_wr_addr_q <= '0;
            rf_wr_data_q <= '0;
            src_q        <= SRC_NONE;
        end else begin
            rf_wr_en_q   <= rf_wr_en_d;
            rf_wr_addr_q <= rf_wr_addr_d;
            rf_wr_data_q <= rf_wr_data_d;
            src_q        <= src_d;
        end
    end

    // An MDU result sitting in the output registers is still in flight.
    assign chk_busy1 = (chk_addr1 != '0) &&
                       (hit1 || (rf_wr_en_q && (src_q == SRC_MDU) && (rf_wr_addr_q == chk_addr1)));
    assign chk_busy2 = (chk_addr2 != '0) &&
                       (hit2 || (rf_wr_en_q && (src_q == SRC_MDU) && (rf_wr_addr_q == chk_addr2)));

    assign rf_wr_en   = rf_wr_en_q;
    assign rf_wr_addr = rf_wr_addr_q;
    assign rf_wr_data = rf_wr_data_q;

`ifdef WB_TRACE_EN
    always @(posedge clk) begin
        if (rst_n && rf_wr_en_q) begin
            $display("wb_trace %s addr=%0d data=%08h q_count=%0d",
                     (src_q == SRC_MDU) ? "MDU" : "PIPE", rf_wr_addr_q, rf_wr_data_q, q_count);
        end
    end
`else
    // Default build produces no simulation output.
`endif

endmodule
